// File: rtl/somador_subtrator_modular_pkg.sv
// Shared constants for the modular add/subtract unit: operation select codes and default sizing.
package somador_subtrator_modular_pkg;
  localparam int N_PADRAO      = 8;
  localparam int LIMITE_PADRAO = 160;

  typedef enum logic {
    OP_SUB  = 1'b0,
    OP_SOMA = 1'b1
  } op_e;

  localparam logic SEL_SOMA = OP_SOMA;
  localparam logic SEL_SUB  = OP_SUB;
endpackage

// File: rtl/somador_subtrator.sv
// Combinational N-bit adder/subtractor with an (N+1)-bit raw result:
// zero-extended sum, or two's-complement difference.
module somador_subtrator
  import somador_subtrator_modular_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         select,
  output logic [N:0]   resultado
);

  always_comb begin
    if (select == SEL_SOMA) resultado = {1'b0, a} + {1'b0, b};
    else                    resultado = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/somador_subtrator_modular.sv
// Two-stage valid/ready add/subtract with wrap-around at LIMITE.
// Define SATURACAO_EN to add the modo_saturacao port and clamp-instead-of-wrap behaviour.
module somador_subtrator_modular
  import somador_subtrator_modular_pkg::*;
#(
  parameter int N      = N_PADRAO,
  parameter int LIMITE = LIMITE_PADRAO
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         select,
`ifdef SATURACAO_EN
  input  logic         modo_saturacao,
`endif
  output logic         saida_valida,
  input  logic         saida_pronta,
  output logic [N-1:0] resul,
  output logic [N:0]   resul_bruto,
  output logic         transbordo,
  output logic         erro
);

  localparam logic [N:0] LIM = (N+1)'(LIMITE);

  logic [N:0]   raw_p0;
  logic         erro_p0;
  logic         load_p1, load_p2;

  logic         vld_p1_q, vld_p1_d;
  logic [N:0]   raw_p1_q, raw_p1_d;
  logic         sel_p1_q, sel_p1_d;
  logic         erro_p1_q, erro_p1_d;
`ifdef SATURACAO_EN
  logic         sat_p1_q, sat_p1_d;
`endif

  logic         vld_p2_q, vld_p2_d;
  logic [N-1:0] resul_p2_q, resul_p2_d;
  logic [N:0]   bruto_p2_q, bruto_p2_d;
  logic         transbordo_p2_q, transbordo_p2_d;
  logic         erro_p2_q, erro_p2_d;

  logic         soma_estouro, sub_estouro;
  logic [N-1:0] resul_corr;

  // Stage 0: raw arithmetic and range check on the incoming operands
  somador_subtrator #(.N(N)) u_somador_subtrator (
    .a        (a),
    .b        (b),
    .select   (select),
    .resultado(raw_p0)
  );

  assign erro_p0 = ({1'b0, a} >= LIM) | ({1'b0, b} >= LIM);

  // Handshake: a stage loads when it is empty or its content moves on this edge
  assign load_p2        = !vld_p2_q | saida_pronta;
  assign load_p1        = !vld_p1_q | load_p2;
  assign entrada_pronta = load_p1;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    raw_p1_d  = raw_p1_q;
    sel_p1_d  = sel_p1_q;
    erro_p1_d = erro_p1_q;
`ifdef SATURACAO_EN
    sat_p1_d  = sat_p1_q;
`endif
    if (load_p1) begin
      vld_p1_d = entrada_valida;
      if (entrada_valida) begin
        raw_p1_d  = raw_p0;
        sel_p1_d  = select;
        erro_p1_d = erro_p0;
`ifdef SATURACAO_EN
        sat_p1_d  = modo_saturacao;
`endif
      end
    end
  end

  // Stage 1 -> 2: modular correction of the raw result
  always_comb begin
    soma_estouro = (sel_p1_q == SEL_SOMA) && (raw_p1_q >= LIM);
    sub_estouro  = (sel_p1_q == SEL_SUB) && raw_p1_q[N];
    if (soma_estouro)     resul_corr = N'(raw_p1_q - LIM);
    else if (sub_estouro) resul_corr = N'(raw_p1_q + LIM);
    else                  resul_corr = raw_p1_q[N-1:0];
`ifdef SATURACAO_EN
    if (sat_p1_q) begin
      if (soma_estouro)     resul_corr = N'(LIM - (N+1)'(1));
      else if (sub_estouro) resul_corr = '0;
    end
`endif
  end

  always_comb begin
    vld_p2_d        = vld_p2_q;
    resul_p2_d      = resul_p2_q;
    bruto_p2_d      = bruto_p2_q;
    transbordo_p2_d = transbordo_p2_q;
    erro_p2_d       = erro_p2_q;
    if (load_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        bruto_p2_d      = raw_p1_q;
        erro_p2_d       = erro_p1_q;
        resul_p2_d      = erro_p1_q ? '0 : resul_corr;
        transbordo_p2_d = !erro_p1_q && (soma_estouro || sub_estouro);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q        <= 1'b0;
      raw_p1_q        <= '0;
      sel_p1_q        <= 1'b0;
      erro_p1_q       <= 1'b0;
`ifdef SATURACAO_EN
      sat_p1_q        <= 1'b0;
`endif
      vld_p2_q        <= 1'b0;
      resul_p2_q      <= '0;
      bruto_p2_q      <= '0;
      transbordo_p2_q <= 1'b0;
      erro_p2_q       <= 1'b0;
    end else begin
      vld_p1_q        <= vld_p1_d;
      raw_p1_q        <= raw_p1_d;
      sel_p1_q        <= sel_p1_d;
      erro_p1_q       <= erro_p1_d;
`ifdef SATURACAO_EN
      sat_p1_q        <= sat_p1_d;
`endif
      vld_p2_q        <= vld_p2_d;
      resul_p2_q      <= resul_p2_d;
      bruto_p2_q      <= bruto_p2_d;
      transbordo_p2_q <= transbordo_p2_d;
      erro_p2_q       <= erro_p2_d;
    end
  end

  assign saida_valida = vld_p2_q;
  assign resul        = resul_p2_q;
  assign resul_bruto  = bruto_p2_q;
  assign transbordo   = transbordo_p2_q;
  assign erro         = erro_p2_q;

endmodule

// File: tb/tb_somador_subtrator_modular.sv
// Self-checking bench for somador_subtrator_modular (N=8, LIMITE=160); define SATURACAO_EN
// to also exercise the clamp mode.
module tb_somador_subtrator_modular;
  localparam int N = 8;
  localparam int L = 160;

  logic         clock = 1'b0;
  logic         reset;
  logic         entrada_valida;
  logic         entrada_pronta;
  logic [N-1:0] a, b;
  logic         select;
`ifdef SATURACAO_EN
  logic         modo_saturacao;
`endif
  logic         saida_valida;
  logic         saida_pronta;
  logic [N-1:0] resul;
  logic [N:0]   resul_bruto;
  logic         transbordo;
  logic         erro;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [N-1:0] r;
    logic [N:0]   bruto;
    logic         t;
    logic         e;
  } exp_t;

  exp_t fila[$];

  somador_subtrator_modular #(.N(N), .LIMITE(L)) dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta),
    .a             (a),
    .b             (b),
    .select        (select),
`ifdef SATURACAO_EN
    .modo_saturacao(modo_saturacao),
`endif
    .saida_valida  (saida_valida),
    .saida_pronta  (saida_pronta),
    .resul         (resul),
    .resul_bruto   (resul_bruto),
    .transbordo    (transbordo),
    .erro          (erro)
  );

  always #5 clock = ~clock;

  // Reference: plain integer arithmetic on the screen-coordinate rules
  function automatic exp_t modelo(int aa, int bb, bit sel, bit sat);
    exp_t x;
    int s;
    s = sel ? aa + bb : aa - bb;
    x.bruto = 9'((s + 512) % 512);
    x.e = (aa >= L) || (bb >= L);
    if (x.e) begin
      x.r = '0; x.t = 1'b0;
    end else if (s >= L) begin
      x.r = sat ? 8'(L - 1) : 8'(s - L); x.t = 1'b1;
    end else if (s < 0) begin
      x.r = sat ? 8'd0 : 8'(s + L); x.t = 1'b1;
    end else begin
      x.r = 8'(s); x.t = 1'b0;
    end
    return x;
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; entrada_valida = 1'b0; saida_pronta = 1'b1;
    a = '0; b = '0; select = 1'b1;
`ifdef SATURACAO_EN
    modo_saturacao = 1'b0;
`endif
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if ({saida_valida, resul, resul_bruto, transbordo, erro} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%0d bruto=%0d t=%b e=%b, want all 0",
               saida_valida, resul, resul_bruto, transbordo, erro);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    n_tests++;
    if (entrada_pronta !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pronta: got %b want 1", entrada_pronta);
    end
  endtask

  task automatic test_directed();
    int ta[6] = '{100, 150, 100, 5, 3, 80};
    int tb_[6] = '{50, 20, 60, 10, 1, 80};
    bit ts[6] = '{1, 1, 1, 0, 0, 0};
    int tr[6] = '{150, 10, 0, 155, 2, 0};
    int tbr[6] = '{150, 170, 160, 507, 2, 0};
    bit tt[6] = '{0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      a = 8'(ta[i]); b = 8'(tb_[i]); select = ts[i]; entrada_valida = 1'b1;
      @(negedge clock);
      entrada_valida = 1'b0;
      #1;
      n_tests++;
      if (saida_valida !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early[%0d]: saida_valida=%b want 0", i, saida_valida);
      end
      @(negedge clock);
      #1;
      n_tests++;
      if (saida_valida !== 1'b1 || resul !== 8'(tr[i]) || resul_bruto !== 9'(tbr[i]) ||
          transbordo !== tt[i] || erro !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b r=%0d bruto=%0d t=%b e=%b, want v=1 r=%0d bruto=%0d t=%b e=0",
                 i, saida_valida, resul, resul_bruto, transbordo, erro, tr[i], tbr[i], tt[i]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int oa[3] = '{100, 150, 5};
    int ob[3] = '{50, 20, 10};
    bit os[3] = '{1, 1, 0};
    int orr[3] = '{150, 10, 155};
    int idx = 0;
    @(negedge clock);
    saida_pronta = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clock);
      a = 8'(oa[idx]); b = 8'(ob[idx]); select = os[idx]; entrada_valida = 1'b1;
      #1;
      if (c >= 2) begin
        n_tests++;
        if (saida_valida !== 1'b1 || resul !== 8'd150 || entrada_pronta !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_frozen[%0d]: got v=%b r=%0d pronta=%b, want v=1 r=150 pronta=0",
                   c, saida_valida, resul, entrada_pronta);
        end
      end
      if (entrada_pronta) idx++;
    end
    n_tests++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL stall_accepted: got %0d ops accepted, want 2", idx);
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      saida_pronta = 1'b1;
      if (idx < 3) begin
        a = 8'(oa[idx]); b = 8'(ob[idx]); select = os[idx]; entrada_valida = 1'b1;
      end else begin
        entrada_valida = 1'b0;
      end
      #1;
      if (entrada_valida && entrada_pronta) idx++;
      n_tests++;
      if (saida_valida !== 1'b1 || resul !== 8'(orr[r])) begin
        n_fail++;
        $display("FAIL release_order[%0d]: got v=%b r=%0d, want v=1 r=%0d",
                 r, saida_valida, resul, orr[r]);
      end
    end
    @(negedge clock);
    entrada_valida = 1'b0;
    #1;
    n_tests++;
    if (saida_valida !== 1'b0) begin
      n_fail++;
      $display("FAIL release_dup: saida_valida=%b want 0 (extra result)", saida_valida);
    end
  endtask

  task automatic test_erro_flush();
    int stale = 0;
    @(negedge clock);
    a = 8'd200; b = 8'd1; select = 1'b1; entrada_valida = 1'b1; saida_pronta = 1'b1;
    @(negedge clock);
    entrada_valida = 1'b0;
    @(negedge clock);
    #1;
    n_tests++;
    if (saida_valida !== 1'b1 || erro !== 1'b1 || resul !== 8'd0 || transbordo !== 1'b0 ||
        resul_bruto !== 9'd201) begin
      n_fail++;
      $display("FAIL erro_range: got v=%b e=%b r=%0d t=%b bruto=%0d, want v=1 e=1 r=0 t=0 bruto=201",
               saida_valida, erro, resul, transbordo, resul_bruto);
    end
    @(negedge clock);
    saida_pronta = 1'b0;
    a = 8'd10; b = 8'd20; select = 1'b1; entrada_valida = 1'b1;
    @(negedge clock);
    a = 8'd30; b = 8'd5; select = 1'b0;
    @(negedge clock);
    entrada_valida = 1'b0; reset = 1'b1;
    @(negedge clock);
    #1;
    n_tests++;
    if ({saida_valida, resul, resul_bruto, transbordo, erro} !== '0) begin
      n_fail++;
      $display("FAIL reset_flush: got v=%b r=%0d bruto=%0d t=%b e=%b, want all 0",
               saida_valida, resul, resul_bruto, transbordo, erro);
    end
    reset = 1'b0; saida_pronta = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      if (saida_valida) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL reset_stale: got %0d stale results, want 0", stale);
    end
  endtask

  task automatic test_random();
    exp_t e, x;
    bit sat;
    bit stall_prev = 1'b0;
    logic [N-1:0] r_prev;
    logic [N:0] br_prev;
    logic t_prev, e_prev;
    int drain;
    fila.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      entrada_valida = ($urandom_range(0, 9) < 7);
      saida_pronta = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, L - 1));
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, L - 1));
      select = 1'($urandom_range(0, 1));
`ifdef SATURACAO_EN
      modo_saturacao = 1'($urandom_range(0, 1));
      sat = modo_saturacao;
`else
      sat = 1'b0;
`endif
      #1;
      if (stall_prev) begin
        n_tests++;
        if (saida_valida !== 1'b1 || resul !== r_prev || resul_bruto !== br_prev ||
            transbordo !== t_prev || erro !== e_prev) begin
          n_fail++;
          $display("FAIL rand_hold[%0d]: got v=%b r=%0d bruto=%0d, want v=1 r=%0d bruto=%0d",
                   c, saida_valida, resul, resul_bruto, r_prev, br_prev);
        end
      end
      stall_prev = saida_valida && !saida_pronta;
      r_prev = resul; br_prev = resul_bruto; t_prev = transbordo; e_prev = erro;
      if (saida_valida && saida_pronta) begin
        n_tests++;
        if (fila.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra[%0d]: got result r=%0d with none pending", c, resul);
        end else begin
          e = fila.pop_front();
          if (resul !== e.r || resul_bruto !== e.bruto || transbordo !== e.t || erro !== e.e) begin
            n_fail++;
            $display("FAIL rand_data[%0d]: got r=%0d bruto=%0d t=%b e=%b, want r=%0d bruto=%0d t=%b e=%b",
                     c, resul, resul_bruto, transbordo, erro, e.r, e.bruto, e.t, e.e);
          end
        end
      end
      if (entrada_valida && entrada_pronta) begin
        x = modelo(int'(a), int'(b), select, sat);
        fila.push_back(x);
      end
    end
    drain = 0;
    while ((fila.size() != 0 || saida_valida) && drain < 20) begin
      @(negedge clock);
      entrada_valida = 1'b0; saida_pronta = 1'b1;
      #1;
      if (saida_valida) begin
        n_tests++;
        if (fila.size() == 0) begin
          n_fail++;
          $display("FAIL drain_extra: got result r=%0d with none pending", resul);
        end else begin
          e = fila.pop_front();
          if (resul !== e.r || resul_bruto !== e.bruto || transbordo !== e.t || erro !== e.e) begin
            n_fail++;
            $display("FAIL drain_data: got r=%0d bruto=%0d t=%b e=%b, want r=%0d bruto=%0d t=%b e=%b",
                     resul, resul_bruto, transbordo, erro, e.r, e.bruto, e.t, e.e);
          end
        end
      end
      drain++;
    end
    n_tests++;
    if (fila.size() != 0) begin
      n_fail++;
      $display("FAIL drain_lost: got %0d results missing, want 0", fila.size());
    end
  endtask

`ifdef SATURACAO_EN
  task automatic test_saturacao();
    int sa[2] = '{150, 5};
    int sb[2] = '{20, 10};
    bit ss[2] = '{1, 0};
    int sr[2] = '{159, 0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      a = 8'(sa[i]); b = 8'(sb[i]); select = ss[i]; modo_saturacao = 1'b1;
      entrada_valida = 1'b1; saida_pronta = 1'b1;
      @(negedge clock);
      entrada_valida = 1'b0;
      @(negedge clock);
      #1;
      n_tests++;
      if (saida_valida !== 1'b1 || resul !== 8'(sr[i]) || transbordo !== 1'b1) begin
        n_fail++;
        $display("FAIL saturacao[%0d]: got v=%b r=%0d t=%b, want v=1 r=%0d t=1",
                 i, saida_valida, resul, transbordo, sr[i]);
      end
    end
    @(negedge clock);
    modo_saturacao = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_erro_flush();
`ifdef SATURACAO_EN
    test_saturacao();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
